// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

  localparam int WIDTH = 4;
  localparam logic [1:0] ITER_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Four-bit ripple carry adder built from a chain of full-adder cells.
module shift_add_multiplier_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[4];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift per clock through the
// ripple carry adder, four iterations per product, start/done handshake.
module shift_add_multiplier #(
  parameter int WIDTH = shift_add_multiplier_pkg::WIDTH
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  import shift_add_multiplier_pkg::*;

  if (WIDTH != 4) begin : g_width_check
    $error("shift_add_multiplier: only WIDTH=4 is supported by the 4-bit adder");
  end

  state_t     state;
  logic [3:0] m_reg;
  logic [7:0] acc;
  logic [1:0] count;

  logic [3:0] add_b;
  logic [3:0] add_s;
  logic       add_c_out;
  logic [7:0] acc_nxt;

  // The low acc bit is the current multiplier bit; it gates the multiplicand.
  assign add_b   = acc[0] ? m_reg : 4'b0;
  assign acc_nxt = {add_c_out, add_s, acc[3:1]};

  shift_add_multiplier_adder u_adder (
    .a     (acc[7:4]),
    .b     (add_b),
    .c_in  (1'b0),
    .s     (add_s),
    .c_out (add_c_out)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      m_reg   <= 4'd0;
      acc     <= 8'd0;
      count   <= 2'd0;
      product <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a;
            acc   <= {4'b0, b};
            count <= 2'd0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          count <= count + 2'd1;
          // The final iteration publishes the freshly shifted accumulator.
          if (count == ITER_LAST) begin
            product <= acc_nxt;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for the shift-and-add multiplier.
module tb_shift_add_multiplier;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  shift_add_multiplier dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 Clock = ~Clock;

  // Drive a start pulse so that the next rising edge (E0) samples it; returns
  // at the falling edge after E0.
  task automatic go(input logic [3:0] av, input logic [3:0] bv);
    @(negedge Clock);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  // Step falling edges until done is seen (bounded); counts busy-high samples.
  task automatic wait_done(output bit seen, output int nbusy);
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (product !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: product=%0d busy=%b done=%b, expected 0/0/0", product, busy, done);
    end
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b done=%b, expected 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    bit seen;
    int nbusy;
    go(4'd13, 4'd11);
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || nbusy != 4) begin
      n_bad++;
      $display("FAIL basic_latency: seen=%b busy_cycles=%0d, expected 1/4", seen, nbusy);
    end
    n_cmp++;
    if (product !== 8'h8F || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_product: product=%0d busy=%b, expected 143/0", product, busy);
    end
    @(negedge Clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_width: done=%b, expected 0", done);
    end
    repeat (3) @(negedge Clock);
    n_cmp++;
    if (product !== 8'h8F) begin
      n_bad++;
      $display("FAIL basic_hold: product=%0d, expected 143", product);
    end
  endtask

  task automatic test_carry();
    bit seen;
    int nbusy;
    go(4'd15, 4'd15);
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || product !== 8'hE1) begin
      n_bad++;
      $display("FAIL carry_15x15: seen=%b product=%0d, expected 1/225", seen, product);
    end
  endtask

  task automatic test_zero();
    bit seen;
    int nbusy;
    go(4'd0, 4'd9);
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || nbusy != 4 || product !== 8'd0) begin
      n_bad++;
      $display("FAIL zero_a: seen=%b busy_cycles=%0d product=%0d, expected 1/4/0", seen, nbusy, product);
    end
    go(4'd9, 4'd0);
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || nbusy != 4 || product !== 8'd0) begin
      n_bad++;
      $display("FAIL zero_b: seen=%b busy_cycles=%0d product=%0d, expected 1/4/0", seen, nbusy, product);
    end
    @(negedge Clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done_width: done=%b, expected 0", done);
    end
  endtask

  task automatic test_ignore_start();
    bit seen;
    int nbusy;
    go(4'd3, 4'd5);
    @(negedge Clock);
    a = 4'd7;
    b = 4'd7;
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_mid_busy: busy=%b, expected 1", busy);
    end
    @(negedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (done !== 1'b1 || product !== 8'd15) begin
      n_bad++;
      $display("FAIL ignore_mid_product: done=%b product=%0d, expected 1/15", done, product);
    end
    // Request held through the DONE cycle: ignored there, accepted one edge later.
    start = 1'b1;
    @(negedge Clock);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 8'd15) begin
      n_bad++;
      $display("FAIL ignore_done_cycle: done=%b busy=%b product=%0d, expected 0/0/15", done, busy, product);
    end
    @(negedge Clock);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_after_done: busy=%b, expected 1", busy);
    end
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || nbusy != 4 || product !== 8'd49) begin
      n_bad++;
      $display("FAIL accept_product: seen=%b busy_cycles=%0d product=%0d, expected 1/4/49", seen, nbusy, product);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    int nbusy;
    go(4'd2, 4'd3);
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || product !== 8'd6) begin
      n_bad++;
      $display("FAIL pre_reset_product: seen=%b product=%0d, expected 1/6", seen, product);
    end
    go(4'd15, 4'd15);
    @(negedge Clock);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (product !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: product=%0d busy=%b done=%b, expected 0/0/0", product, busy, done);
    end
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%b done=%b product=%0d, expected 0/0/0", busy, done, product);
    end
    go(4'd4, 4'd4);
    wait_done(seen, nbusy);
    n_cmp++;
    if (!seen || nbusy != 4 || product !== 8'd16) begin
      n_bad++;
      $display("FAIL post_reset_product: seen=%b busy_cycles=%0d product=%0d, expected 1/4/16", seen, nbusy, product);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int nbusy;
    int ndone = 0;
    logic [7:0] exp_p;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        go(4'(ia), 4'(ib));
        wait_done(seen, nbusy);
        exp_p = 8'(ia * ib);
        if (seen) ndone++;
        n_cmp++;
        if (!seen || product !== exp_p) begin
          n_bad++;
          $display("FAIL exhaustive %0dx%0d: seen=%b product=%0d, expected 1/%0d", ia, ib, seen, product, exp_p);
        end
      end
    end
    n_cmp++;
    if (ndone != 256) begin
      n_bad++;
      $display("FAIL exhaustive_done_count: got %0d, expected 256", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
